// File: rtl/matrix_16x6_sequencer.sv
// rtl/matrix_16x6_sequencer.sv - sequences a 16x6 matrix multiplier for one fully-connected layer pass
// Loads 96 column-major weights, streams NVEC 16-word vectors and serialises the 6 results of each.
module matrix_16x6_sequencer #(
    parameter int DIM     = 16,
    parameter int AW      = 4,
    parameter int DW      = 24,
    parameter int NCOL    = 6,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [15:0]   CFG_NVEC,
    input  logic          CFG_SKIP_W,
    input  logic [2:0]    CFG_PHASE,
    input  logic          WT_VALID,
    output logic          WT_READY,
    input  logic [DW-1:0] WT_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] IN_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          W_WEN,
    output logic          W_REN,
    output logic [AW+5:0] W_ADDR,
    output logic [DW-1:0] W_WDATA,
    output logic [2:0]    PHASE_SEL,
    output logic          DIN_VALID,
    output logic [DW-1:0] DIN,
    input  logic          MM_VALID,
    input  logic [DW-1:0] MM_OUT1,
    input  logic [DW-1:0] MM_OUT2,
    input  logic [DW-1:0] MM_OUT3,
    input  logic [DW-1:0] MM_OUT4,
    input  logic [DW-1:0] MM_OUT5,
    input  logic [DW-1:0] MM_OUT6,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_WAIT_RES,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [15:0]     vec_q, vec_d;
    logic [15:0]     nvec_q, nvec_d;
    logic [2:0]      k_q, k_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic [2:0]      phase_q, phase_d;
    logic            err_q, err_d;
    logic [DW-1:0]   res_q [NCOL];
    logic [DW-1:0]   res_d [NCOL];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            vec_q   <= '0;
            nvec_q  <= '0;
            k_q     <= '0;
            wait_q  <= '0;
            phase_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NCOL; i++) res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            vec_q   <= vec_d;
            nvec_q  <= nvec_d;
            k_q     <= k_d;
            wait_q  <= wait_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            for (int i = 0; i < NCOL; i++) res_q[i] <= res_d[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        vec_d     = vec_q;
        nvec_d    = nvec_q;
        k_d       = k_q;
        wait_d    = wait_q;
        phase_d   = phase_q;
        err_d     = err_q;
        res_d     = res_q;
        WT_READY  = 1'b0;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        OUT_DATA  = '0;
        W_WEN     = 1'b0;
        W_REN     = 1'b0;
        W_ADDR    = '0;
        W_WDATA   = '0;
        DIN_VALID = 1'b0;
        DIN       = '0;
        DONE      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    nvec_d  = CFG_NVEC;
                    phase_d = CFG_PHASE;
                    err_d   = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    vec_d   = '0;
                    k_d     = '0;
                    if (!CFG_SKIP_W)        state_d = S_LOAD_W;
                    else if (CFG_NVEC == 0) state_d = S_FIN;
                    else                    state_d = S_STREAM;
                end
            end
            S_LOAD_W: begin
                WT_READY = 1'b1;
                if (WT_VALID) begin
                    W_WEN   = 1'b1;
                    W_WDATA = WT_DATA;
                    W_ADDR  = {1'b0, col_q, 2'b00, row_q};
                    if (row_q == AW'(DIM - 1)) begin
                        row_d = '0;
                        if (col_q == 3'(NCOL - 1)) begin
                            col_d   = '0;
                            state_d = (nvec_q == 0) ? S_FIN : S_STREAM;
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_STREAM: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    DIN_VALID = 1'b1;
                    DIN       = IN_DATA;
                    if (row_q == AW'(DIM - 1)) begin
                        row_d   = '0;
                        wait_d  = '0;
                        state_d = S_WAIT_RES;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_WAIT_RES: begin
                // A result arriving on the last allowed cycle still wins over the abort.
                if (MM_VALID) begin
                    res_d[0] = MM_OUT1;
                    res_d[1] = MM_OUT2;
                    res_d[2] = MM_OUT3;
                    res_d[3] = MM_OUT4;
                    res_d[4] = MM_OUT5;
                    res_d[5] = MM_OUT6;
                    k_d      = '0;
                    state_d  = S_DRAIN;
                end else if (wait_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DRAIN: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = res_q[k_q];
                if (OUT_READY) begin
                    if (k_q == 3'(NCOL - 1)) begin
                        k_d     = '0;
                        vec_d   = vec_q + 16'd1;
                        state_d = (vec_q + 16'd1 == nvec_q) ? S_FIN : S_STREAM;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end
            end
            S_FIN: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Unsolicited results are dropped but flagged.
        if (MM_VALID && state_q != S_WAIT_RES) err_d = 1'b1;
    end

    assign PHASE_SEL = phase_q;
    assign BUSY      = (state_q != S_IDLE);
    assign ERR       = err_q;

endmodule

// File: tb/tb_matrix_16x6_sequencer.sv
// tb/tb_matrix_16x6_sequencer.sv - directed self-checking bench for matrix_16x6_sequencer
module tb_matrix_16x6_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_nvec = '0;
    logic        cfg_skip_w = 1'b0;
    logic [2:0]  cfg_phase = '0;
    logic        wt_valid = 1'b0;
    logic        wt_ready;
    logic [23:0] wt_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
    logic        w_wen, w_ren;
    logic [9:0]  w_addr;
    logic [23:0] w_wdata;
    logic [2:0]  phase_sel;
    logic        din_valid;
    logic [23:0] din;
    logic        mm_valid;
    logic        busy, done, err;

    logic        mm_en = 1'b1;
    logic        mm_force = 1'b0;
    logic        mm_vq;
    logic [3:0]  mm_idx;
    logic [1:0]  mm_dly;
    logic [23:0] mm_mem [16];
    int          din_count = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mm_valid = mm_vq | mm_force;

    matrix_16x6_sequencer dut (
        .CLK(clk), .RST(rst), .START(start), .CFG_NVEC(cfg_nvec), .CFG_SKIP_W(cfg_skip_w),
        .CFG_PHASE(cfg_phase), .WT_VALID(wt_valid), .WT_READY(wt_ready), .WT_DATA(wt_data),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_DATA(out_data), .W_WEN(w_wen), .W_REN(w_ren),
        .W_ADDR(w_addr), .W_WDATA(w_wdata), .PHASE_SEL(phase_sel), .DIN_VALID(din_valid),
        .DIN(din), .MM_VALID(mm_valid), .MM_OUT1(mm_mem[0]), .MM_OUT2(mm_mem[1]),
        .MM_OUT3(mm_mem[2]), .MM_OUT4(mm_mem[3]), .MM_OUT5(mm_mem[4]), .MM_OUT6(mm_mem[5]),
        .BUSY(busy), .DONE(done), .ERR(err)
    );

    // Multiplier stand-in: OUTPUTj echoes vector word j-1, VALID three cycles after word 16.
    always @(posedge clk) begin
        if (rst) begin
            mm_idx <= '0;
            mm_dly <= '0;
            mm_vq  <= 1'b0;
        end else begin
            mm_vq <= 1'b0;
            if (din_valid) begin
                mm_mem[mm_idx] <= din;
                din_count      <= din_count + 1;
                mm_idx         <= mm_idx + 4'd1;
                if (mm_idx == 4'd15) mm_dly <= 2'd3;
            end
            if (mm_dly != 0) begin
                mm_dly <= mm_dly - 2'd1;
                if (mm_dly == 2'd1 && mm_en) mm_vq <= 1'b1;
            end
        end
    end

    wire [93:0] all_out = {wt_ready, in_ready, out_valid, out_data, w_wen, w_ren, w_addr,
                           w_wdata, phase_sel, din_valid, din, busy, done, err};

    function automatic logic [23:0] wd(input int i);
        return 24'h5A0000 ^ 24'(i);
    endfunction

    function automatic logic [23:0] vw(input int v, input int i);
        return 24'hA00000 + 24'(v * 'h1000) + 24'(i * 'h11);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pass(input int nvec, input logic skip, input logic [2:0] ph);
        start = 1'b1;
        cfg_nvec = 16'(nvec);
        cfg_skip_w = skip;
        cfg_phase = ph;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_weights(input int n);
        logic [9:0] ea;
        for (int i = 0; i < n; i++) begin
            if (i == 50) begin
                wt_valid = 1'b0;
                #1 chk("w_gap", {wt_ready, w_wen}, 2'b10);
                @(negedge clk);
            end
            wt_valid = 1'b1;
            wt_data  = wd(i);
            ea = {1'b0, 3'(i / 16), 2'b00, 4'(i % 16)};
            #1 chk($sformatf("w_write%0d", i), {wt_ready, w_wen, w_addr, w_wdata}, {2'b11, ea, wd(i)});
            if (i == 95) chk("w_addr_last", w_addr, 10'h14F);
            @(negedge clk);
        end
        wt_valid = 1'b0;
    endtask

    task automatic send_vec(input int v);
        for (int i = 0; i < 16; i++) begin
            if (i == 7) begin
                in_valid = 1'b0;
                #1 chk("din_gap", {in_ready, din_valid}, 2'b10);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = vw(v, i);
            #1 chk($sformatf("din_v%0d_w%0d", v, i), {in_ready, din_valid, din}, {2'b11, vw(v, i)});
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1 chk("in_ready_wait", {in_ready, out_valid}, 2'b00);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", out_valid, 1'b1);
    endtask

    task automatic drain_vec(input int v);
        wait_out();
        for (int k = 0; k < 6; k++) begin
            out_ready = 1'b1;
            #1 chk($sformatf("out_v%0d_k%0d", v, k), {out_valid, out_data}, {1'b1, vw(v, k)});
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int din_base;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", all_out, 94'd0);

        // One vector with full weight load
        start_pass(1, 1'b0, 3'd5);
        chk("a_started", {busy, wt_ready, phase_sel, err}, {2'b11, 3'd5, 1'b0});
        load_weights(96);
        chk("a_stream", {wt_ready, in_ready, w_wen}, 3'b010);
        send_vec(0);
        drain_vec(0);
        chk("a_done", {done, busy, err}, 3'b110);
        @(negedge clk);
        chk("a_idle", {done, busy}, 2'b00);

        // Two vectors, weights reused, OUT_READY held low, START while busy
        din_base = din_count;
        start_pass(2, 1'b1, 3'd3);
        chk("b_skip_to_stream", {busy, in_ready, wt_ready, phase_sel}, {3'b110, 3'd3});
        start = 1'b1;
        cfg_nvec = 16'd0;
        cfg_phase = 3'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b_start_ignored", {busy, in_ready, phase_sel, done}, {2'b11, 3'd3, 1'b0});
        send_vec(1);
        wait_out();
        in_valid = 1'b1;
        in_data = 24'h123456;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("b_stall%0d", c), {out_valid, out_data, in_ready, din_valid},
                {1'b1, vw(1, 0), 2'b00});
        end
        in_valid = 1'b0;
        drain_vec(1);
        chk("b_between", {busy, done, in_ready}, 3'b101);
        send_vec(2);
        drain_vec(2);
        chk("b_done", {done, busy}, 2'b11);
        chk("b_din_count", din_count - din_base, 32);
        @(negedge clk);
        chk("b_idle", {done, busy, err}, 3'b000);

        // Reuse weights with zero vectors
        start_pass(0, 1'b1, 3'd1);
        chk("c_done", {done, busy, w_wen, din_valid}, 4'b1100);
        @(negedge clk);
        chk("c_idle", {done, busy}, 2'b00);

        // Stray multiplier result while idle
        mm_force = 1'b1;
        @(negedge clk);
        mm_force = 1'b0;
        chk("stray_err", {err, busy}, 2'b10);

        // Multiplier never answers
        mm_en = 1'b0;
        start_pass(1, 1'b1, 3'd4);
        chk("d_err_cleared", {err, busy}, 2'b01);
        send_vec(5);
        cnt = 1;
        while (!done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk("d_timeout_cycles", cnt, 257);
        chk("d_timeout_flags", {err, busy, done}, 3'b111);
        @(negedge clk);
        chk("d_idle", {err, busy, done}, 3'b100);
        mm_en = 1'b1;

        // Reset in the middle of the weight load
        start_pass(1, 1'b0, 3'd2);
        load_weights(39);
        rst = 1'b1;
        wt_valid = 1'b1;
        wt_data = wd(39);
        @(negedge clk);
        rst = 1'b0;
        wt_valid = 1'b0;
        chk("e_reset_outputs", all_out, 94'd0);
        start_pass(1, 1'b0, 3'd2);
        load_weights(96);
        send_vec(3);
        drain_vec(3);
        chk("e_done", {done, busy, err}, 3'b110);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
